me_search_array: RTL

- Parametrised full-search block-matching motion estimator; next generation of the 16-PE SAD array.
- Configurable block size, search range, pixel width, SAD width and number of parallel PEs.
- Adds a start/busy/done handshake, a registered memory-read interface and a deterministic tie-break.
- Sits between the reference/search pixel memories and the encoder's motion-vector consumer.

---
 rtl/me_search_array.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/me_search_array.sv
// Full-search block-matching motion estimator with NUM_PE parallel SAD lanes (one dx per lane).
// Defining ME_SAD_STREAM_EN adds a registered per-candidate SAD stream (sad_valid/value/dx/dy).
module me_search_array #(
   parameter int BLOCK_N = 16,
   parameter int RANGE   = 8,
   parameter int PIX_W   = 8,
   parameter int SAD_W   = 16,
   parameter int NUM_PE  = 16,
   localparam int SW   = BLOCK_N + 2*RANGE,
   localparam int MV_W = $clog2(2*RANGE),
   localparam int AR_W = $clog2(BLOCK_N*BLOCK_N),
   localparam int AS_W = $clog2(SW*SW)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     rd_en_o,
   output logic [AR_W-1:0]          addr_r_o,
   output logic [AS_W-1:0]          addr_s_o,
   input  logic [PIX_W-1:0]         r_data_i,
   input  logic [NUM_PE*PIX_W-1:0]  s_data_i,
   output logic [SAD_W-1:0]         best_sad_o,
   output logic [MV_W-1:0]          mv_x_o,
   output logic [MV_W-1:0]          mv_y_o
`ifdef ME_SAD_STREAM_EN
   ,
   output logic                     sad_valid_o,
   output logic [SAD_W-1:0]         sad_value_o,
   output logic [MV_W-1:0]          sad_dx_o,
   output logic [MV_W-1:0]          sad_dy_o
`endif
);
   localparam int XW   = (BLOCK_N > 1) ? $clog2(BLOCK_N) : 1;
   localparam int LN_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t            state_q;
   logic              busy_q, done_q, rd_en_q;
   logic [AR_W-1:0]   addr_r_q;
   logic [AS_W-1:0]   addr_s_q;
   logic [XW-1:0]     x_q, y_q, x_d, y_d;
   logic [MV_W-1:0]   dx0_q, dy_q, dx0_d, dy_d;
   logic              x_end, y_end, dx_end, dy_end, last_addr, accept;
   logic [SAD_W-1:0]  best_sad_q;
   logic [MV_W-1:0]   mv_x_q, mv_y_q;

   logic              s1_vld_q, s1_first_q, s1_last_q;
   logic [MV_W-1:0]   s1_dy_q, s1_dx0_q;
   logic [PIX_W-1:0]  abs_diff [NUM_PE];
   logic [PIX_W-1:0]  diff_q [NUM_PE];
   logic [SAD_W:0]    acc_sum [NUM_PE];
   logic [SAD_W-1:0]  acc_sat [NUM_PE];
   logic [SAD_W-1:0]  acc_q [NUM_PE];
   logic [SAD_W-1:0]  snap_q [NUM_PE];
   logic              acc_full_q;
   logic [MV_W-1:0]   acc_dy_q, acc_dx0_q, snap_dy_q, snap_dx0_q;
   logic              walk_q, first_cand_q, snap_last, walk_end;
   logic [LN_W-1:0]   lane_q;
   logic [SAD_W-1:0]  best_q, cand_sad;
   logic [MV_W-1:0]   bx_q, by_q, cand_dx, cand_dy;

   assign accept = (state_q == S_IDLE) && start_i;

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      dx0_d  = dx0_q;
      dy_d   = dy_q;
      x_end  = (x_q == XW'(BLOCK_N-1));
      y_end  = (y_q == XW'(BLOCK_N-1));
      dx_end = (dx0_q == MV_W'(2*RANGE-NUM_PE));
      dy_end = (dy_q == MV_W'(2*RANGE-1));
      if (!x_end) begin
         x_d = x_q + XW'(1);
      end else begin
         x_d = '0;
         if (!y_end) begin
            y_d = y_q + XW'(1);
         end else begin
            y_d = '0;
            if (!dx_end) begin
               dx0_d = dx0_q + MV_W'(NUM_PE);
            end else begin
               dx0_d = '0;
               dy_d  = dy_q + MV_W'(1);
            end
         end
      end
      last_addr = x_end && y_end && dx_end && dy_end;
   end

   // Control FSM; the scan counters track the address currently on the bus.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         addr_r_q   <= '0;
         addr_s_q   <= '0;
         x_q        <= '0;
         y_q        <= '0;
         dx0_q      <= '0;
         dy_q       <= '0;
         best_sad_q <= '1;
         mv_x_q     <= '0;
         mv_y_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q  <= S_FETCH;
                  busy_q   <= 1'b1;
                  rd_en_q  <= 1'b1;
                  addr_r_q <= '0;
                  addr_s_q <= '0;
                  x_q      <= '0;
                  y_q      <= '0;
                  dx0_q    <= '0;
                  dy_q     <= '0;
               end
            end
            S_FETCH: begin
               if (last_addr) begin
                  rd_en_q <= 1'b0;
                  state_q <= S_DRAIN;
               end else begin
                  x_q      <= x_d;
                  y_q      <= y_d;
                  dx0_q    <= dx0_d;
                  dy_q     <= dy_d;
                  addr_r_q <= AR_W'(int'(y_d)*BLOCK_N + int'(x_d));
                  addr_s_q <= AS_W'((int'(y_d) + int'(dy_d))*SW + int'(x_d) + int'(dx0_d));
               end
            end
            S_DRAIN: begin
               if (walk_end && snap_last) state_q <= S_DONE;
            end
            S_DONE: begin
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               best_sad_q <= best_q;
               mv_x_q     <= bx_q;
               mv_y_q     <= by_q;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_PE; k++) begin
         abs_diff[k] = (r_data_i >= s_data_i[k*PIX_W +: PIX_W]) ?
                       r_data_i - s_data_i[k*PIX_W +: PIX_W] :
                       s_data_i[k*PIX_W +: PIX_W] - r_data_i;
         acc_sum[k]  = {1'b0, acc_q[k]} + (SAD_W+1)'(diff_q[k]);
         acc_sat[k]  = acc_sum[k][SAD_W] ? '1 : acc_sum[k][SAD_W-1:0];
      end
   end

   assign cand_sad  = snap_q[lane_q];
   assign cand_dx   = snap_dx0_q + MV_W'(lane_q) - MV_W'(RANGE);
   assign cand_dy   = snap_dy_q - MV_W'(RANGE);
   assign walk_end  = walk_q && (lane_q == LN_W'(NUM_PE-1));
   assign snap_last = (snap_dy_q == MV_W'(2*RANGE-1)) && (snap_dx0_q == MV_W'(2*RANGE-NUM_PE));

   // Absolute difference, accumulate, snapshot and serial compare walk.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_vld_q     <= 1'b0;
         s1_first_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_dy_q      <= '0;
         s1_dx0_q     <= '0;
         acc_full_q   <= 1'b0;
         acc_dy_q     <= '0;
         acc_dx0_q    <= '0;
         snap_dy_q    <= '0;
         snap_dx0_q   <= '0;
         walk_q       <= 1'b0;
         lane_q       <= '0;
         first_cand_q <= 1'b0;
         best_q       <= '1;
         bx_q         <= '0;
         by_q         <= '0;
         for (int k = 0; k < NUM_PE; k++) begin
            diff_q[k] <= '0;
            acc_q[k]  <= '0;
            snap_q[k] <= '0;
         end
      end else begin
         s1_vld_q   <= rd_en_q;
         s1_first_q <= (x_q == '0) && (y_q == '0);
         s1_last_q  <= x_end && y_end;
         s1_dy_q    <= dy_q;
         s1_dx0_q   <= dx0_q;
         for (int k = 0; k < NUM_PE; k++) diff_q[k] <= abs_diff[k];

         acc_full_q <= s1_vld_q && s1_last_q;
         if (s1_vld_q) begin
            if (s1_first_q) begin
               acc_dy_q  <= s1_dy_q;
               acc_dx0_q <= s1_dx0_q;
            end
            for (int k = 0; k < NUM_PE; k++)
               acc_q[k] <= s1_first_q ? SAD_W'(diff_q[k]) : acc_sat[k];
         end

         if (acc_full_q) begin
            for (int k = 0; k < NUM_PE; k++) snap_q[k] <= acc_q[k];
            snap_dy_q  <= acc_dy_q;
            snap_dx0_q <= acc_dx0_q;
            walk_q     <= 1'b1;
            lane_q     <= '0;
         end else if (walk_q) begin
            lane_q <= lane_q + LN_W'(1);
            if (walk_end) walk_q <= 1'b0;
         end

         // Strict less-than keeps the earliest candidate on ties.
         if (walk_q && (first_cand_q || (cand_sad < best_q))) begin
            best_q <= cand_sad;
            bx_q   <= cand_dx;
            by_q   <= cand_dy;
         end
         if (accept)      first_cand_q <= 1'b1;
         else if (walk_q) first_cand_q <= 1'b0;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign rd_en_o    = rd_en_q;
   assign addr_r_o   = addr_r_q;
   assign addr_s_o   = addr_s_q;
   assign best_sad_o = best_sad_q;
   assign mv_x_o     = mv_x_q;
   assign mv_y_o     = mv_y_q;

`ifdef ME_SAD_STREAM_EN
   logic              sad_valid_q;
   logic [SAD_W-1:0]  sad_value_q;
   logic [MV_W-1:0]   sad_dx_q, sad_dy_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sad_valid_q <= 1'b0;
         sad_value_q <= '0;
         sad_dx_q    <= '0;
         sad_dy_q    <= '0;
      end else begin
         sad_valid_q <= walk_q;
         if (walk_q) begin
            sad_value_q <= cand_sad;
            sad_dx_q    <= cand_dx;
            sad_dy_q    <= cand_dy;
         end
      end
   end

   assign sad_valid_o = sad_valid_q;
   assign sad_value_o = sad_value_q;
   assign sad_dx_o    = sad_dx_q;
   assign sad_dy_o    = sad_dy_q;
`endif
endmodule
